regfile_wb_sink: RTL and testbench
==================================

# regfile_wb_sink

Integer register file that terminates the writeback stage's register-write interface and serves the decode stage's two source-operand reads. It commits the writeback port's (we, rd_addr, rd_data) triple, keeps x0 hardwired to zero, and bypasses a same-cycle write to a matching read. Read results are registered behind a ce/stall/flush pipeline handshake. While decode is stalled, held operands are refreshed if a late writeback targets them.

## Interface
- DWIDTH, 32, register data width
- AWIDTH, 5, register address width (2^AWIDTH entries)
- wb_clk  in  1  clock, rising edge
- wb_rst  in  1  reset, asynchronous, active-low
- rf_i_we  in  1  writeback write enable (driven from writeback's we_rd output)
- rf_i_rd_addr  in  AWIDTH  writeback destination register
- rf_i_rd_data  in  DWIDTH  writeback data
- rf_i_rs1_addr  in  AWIDTH  source register 1 address
- rf_i_rs2_addr  in  AWIDTH  source register 2 address
- rf_i_ce  in  1  read request valid from the fetch/decode boundary
- rf_i_stall  in  1  downstream stall: hold all read outputs
- rf_i_flush  in  1  squash: drop the read in flight
- rf_o_rs1_data  out  DWIDTH  registered operand 1
- rf_o_rs2_data  out  DWIDTH  registered operand 2
- rf_o_rs1_addr  out  AWIDTH  address captured with rf_o_rs1_data
- rf_o_rs2_addr  out  AWIDTH  address captured with rf_o_rs2_data
- rf_o_ce  out  1  registered operands valid

## Operation
- Storage: 2^AWIDTH x DWIDTH flops. All entries are cleared by reset.
- Write path:
  - At posedge, if rf_i_we=1 and rf_i_rd_addr!=0, then mem[rf_i_rd_addr] <= rf_i_rd_data.
  - Writes are unconditional with respect to ce/stall/flush, because retiring instructions are never squashed here.
  - A write to x0 is discarded.
- Read value function, per port: val(a) = 0 if a==0; else rf_i_rd_data if rf_i_we and rf_i_rd_addr==a (write-first bypass); else mem[a].
- Read pipeline, evaluated each posedge in priority order:
  1. rf_i_flush=1: rf_o_ce <= 0. Data and address outputs hold.
  2. rf_i_stall=1: rf_o_ce holds, and rf_o_rsX_addr holds. For each port, if rf_i_we and rf_i_rd_addr==rf_o_rsX_addr and rf_o_rsX_addr!=0, then rf_o_rsX_data <= rf_i_rd_data (stall refresh); otherwise it holds.
  3. rf_i_ce=1: rf_o_rsX_addr <= rf_i_rsX_addr, rf_o_rsX_data <= val(rf_i_rsX_addr), rf_o_ce <= 1.
  4. Otherwise: rf_o_ce <= 0. Data and address outputs hold.
- Both ports are independent. rs1==rs2 is legal, and both ports return the same value.
- rd_addr equal to both rs1 and rs2 in the same cycle bypasses to both ports.

## Timing
- Reset (wb_rst=0, async): rf_o_rs1_data=0, rf_o_rs2_data=0, rf_o_rs1_addr=0, rf_o_rs2_addr=0, rf_o_ce=0, and every mem entry is 0. Reset mid-operation aborts any read or write in flight.
- Read latency is 1 cycle: addresses presented with rf_i_ce at edge N are valid on the outputs after edge N, with rf_o_ce=1.
- Write visibility:
  - A write at edge N is seen by a read sampled at edge N, via bypass.
  - It is seen by all later reads from storage.
- No cycle exists in which a committed write is invisible to a concurrent read.
- Flush with stall: flush wins, so rf_o_ce=0 after the edge.
- Flush with ce: flush wins, and the read is dropped.
- The write still commits during both flush and stall.
- Stall refresh takes effect on the same edge as the write. The held operand is never older than the last committed write to its address.

## Test plan
- Reset, then read rs1=5, rs2=0 with ce=1 -> after 1 edge rf_o_rs1_data=0, rf_o_rs2_data=0, rf_o_ce=1.
- Write x5=0xDEADBEEF at edge 1. At edge 3 read rs1=5 -> rf_o_rs1_data=0xDEADBEEF.
- Same edge: we=1, rd=7, data=0x12345678, ce=1, rs1=7, rs2=7 -> both outputs 0x12345678 after the edge. The later storage read of x7 also gives 0x12345678.
- Write x0=0xFFFFFFFF, then read rs1=0 -> rf_o_rs1_data=0. Same-cycle write-to-x0 plus read of x0 -> 0, with no bypass.
- Capture rs1=9 (value 0x1). Then stall=1 while writing x9=0x2 -> rf_o_rs1_data=0x2, rf_o_ce stays 1, rf_o_rs1_addr=9. A write to x10 during the stall leaves the outputs unchanged.
- flush=1, stall=1, ce=1 together with we=1, rd=3, data=0x55 -> rf_o_ce=0, outputs hold, and a later read of x3 gives 0x55.

Source files
------------

// File: rtl/regfile_wb_sink.sv
// ---------------------------------------------------------------------------
// regfile_wb_sink
//
// Integer register file sitting between the writeback stage (one write port)
// and the decode stage (two registered source-operand reads).
//
//   - x0 is hardwired to zero: writes to it are dropped and reads of it
//     return zero without consulting the bypass.
//   - A write and a read of the same register on the same edge return the
//     new value (write-first bypass), so no committed write is ever
//     invisible to a concurrent read.
//   - Read results are registered behind a ce/stall/flush handshake.
//   - While decode is stalled, a held operand whose captured address is
//     being written is refreshed on the same edge as the write.
//
// Parameters
//   DWIDTH        register data width
//   AWIDTH        register address width (2**AWIDTH entries)
//
// Ports
//   wb_clk        clock, rising edge
//   wb_rst        asynchronous reset, active low
//   rf_i_we       writeback write enable
//   rf_i_rd_addr  writeback destination register
//   rf_i_rd_data  writeback data
//   rf_i_rs1_addr source register 1 address
//   rf_i_rs2_addr source register 2 address
//   rf_i_ce       read request valid
//   rf_i_stall    hold all read outputs (with late-write refresh)
//   rf_i_flush    drop the read in flight
//   rf_o_rs1_data registered operand 1
//   rf_o_rs2_data registered operand 2
//   rf_o_rs1_addr address captured with rf_o_rs1_data
//   rf_o_rs2_addr address captured with rf_o_rs2_data
//   rf_o_ce       registered operands valid
// ---------------------------------------------------------------------------
module regfile_wb_sink #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              rf_i_we,
  input  logic [AWIDTH-1:0] rf_i_rd_addr,
  input  logic [DWIDTH-1:0] rf_i_rd_data,
  input  logic [AWIDTH-1:0] rf_i_rs1_addr,
  input  logic [AWIDTH-1:0] rf_i_rs2_addr,
  input  logic              rf_i_ce,
  input  logic              rf_i_stall,
  input  logic              rf_i_flush,
  output logic [DWIDTH-1:0] rf_o_rs1_data,
  output logic [DWIDTH-1:0] rf_o_rs2_data,
  output logic [AWIDTH-1:0] rf_o_rs1_addr,
  output logic [AWIDTH-1:0] rf_o_rs2_addr,
  output logic              rf_o_ce
);

  localparam int NREG = 1 << AWIDTH;

  // Handshake: the read side has no ready; the consumer throttles with
  // stall. On each edge, in priority order: flush drops the output valid
  // (data/address hold); stall holds valid and address while refreshing
  // held data from a matching write; ce captures a new read and raises
  // valid; otherwise valid drops and data/address hold. The write side is
  // fire-and-forget: rf_i_we commits on every edge regardless of the read
  // handshake, since retiring instructions are never squashed here.

  logic [DWIDTH-1:0] mem [NREG];

  // Qualified write: x0 writes are discarded everywhere, including bypass.
  logic wr_en;
  assign wr_en = rf_i_we && (rf_i_rd_addr != '0);

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      mem <= '{default: '0};
    end else if (wr_en) begin
      mem[rf_i_rd_addr] <= rf_i_rd_data;
    end
  end

  // -------------------------------------------------------------------------
  // Read value per port: zero for x0, else bypass a same-edge write, else
  // the stored value.
  // -------------------------------------------------------------------------
  logic [DWIDTH-1:0] rs1_val;
  logic [DWIDTH-1:0] rs2_val;

  always_comb begin
    rs1_val = mem[rf_i_rs1_addr];
    if (rf_i_rs1_addr == '0) begin
      rs1_val = '0;
    end else if (wr_en && (rf_i_rd_addr == rf_i_rs1_addr)) begin
      rs1_val = rf_i_rd_data;
    end
  end

  always_comb begin
    rs2_val = mem[rf_i_rs2_addr];
    if (rf_i_rs2_addr == '0) begin
      rs2_val = '0;
    end else if (wr_en && (rf_i_rd_addr == rf_i_rs2_addr)) begin
      rs2_val = rf_i_rd_data;
    end
  end

  // Stall refresh: a write landing on a held operand's address replaces
  // the held data so it is never older than the last committed write.
  // wr_en already excludes x0, so a held x0 operand stays zero.
  logic rs1_refresh;
  logic rs2_refresh;
  assign rs1_refresh = wr_en && (rf_i_rd_addr == rf_o_rs1_addr);
  assign rs2_refresh = wr_en && (rf_i_rd_addr == rf_o_rs2_addr);

  // -------------------------------------------------------------------------
  // Read pipeline register
  // -------------------------------------------------------------------------
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      rf_o_rs1_data <= '0;
      rf_o_rs2_data <= '0;
      rf_o_rs1_addr <= '0;
      rf_o_rs2_addr <= '0;
      rf_o_ce       <= 1'b0;
    end else if (rf_i_flush) begin
      rf_o_ce <= 1'b0;
    end else if (rf_i_stall) begin
      if (rs1_refresh) begin
        rf_o_rs1_data <= rf_i_rd_data;
      end
      if (rs2_refresh) begin
        rf_o_rs2_data <= rf_i_rd_data;
      end
    end else if (rf_i_ce) begin
      rf_o_rs1_addr <= rf_i_rs1_addr;
      rf_o_rs2_addr <= rf_i_rs2_addr;
      rf_o_rs1_data <= rs1_val;
      rf_o_rs2_data <= rs2_val;
      rf_o_ce       <= 1'b1;
    end else begin
      rf_o_ce <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sink.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_sink
//
// Directed bench for regfile_wb_sink: reset values, basic read, write then
// read, same-edge bypass on both ports, x0 behaviour, stall refresh,
// flush priority, and asynchronous reset mid-operation.
// ---------------------------------------------------------------------------
module tb_regfile_wb_sink;

  localparam int DWIDTH = 32;
  localparam int AWIDTH = 5;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic wb_clk = 1'b0;
  logic wb_rst = 1'b0;
  always #5 wb_clk = ~wb_clk;

  logic              rf_i_we;
  logic [AWIDTH-1:0] rf_i_rd_addr;
  logic [DWIDTH-1:0] rf_i_rd_data;
  logic [AWIDTH-1:0] rf_i_rs1_addr;
  logic [AWIDTH-1:0] rf_i_rs2_addr;
  logic              rf_i_ce;
  logic              rf_i_stall;
  logic              rf_i_flush;
  logic [DWIDTH-1:0] rf_o_rs1_data;
  logic [DWIDTH-1:0] rf_o_rs2_data;
  logic [AWIDTH-1:0] rf_o_rs1_addr;
  logic [AWIDTH-1:0] rf_o_rs2_addr;
  logic              rf_o_ce;

  regfile_wb_sink #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
    .wb_clk        (wb_clk),
    .wb_rst        (wb_rst),
    .rf_i_we       (rf_i_we),
    .rf_i_rd_addr  (rf_i_rd_addr),
    .rf_i_rd_data  (rf_i_rd_data),
    .rf_i_rs1_addr (rf_i_rs1_addr),
    .rf_i_rs2_addr (rf_i_rs2_addr),
    .rf_i_ce       (rf_i_ce),
    .rf_i_stall    (rf_i_stall),
    .rf_i_flush    (rf_i_flush),
    .rf_o_rs1_data (rf_o_rs1_data),
    .rf_o_rs2_data (rf_o_rs2_data),
    .rf_o_rs1_addr (rf_o_rs1_addr),
    .rf_o_rs2_addr (rf_o_rs2_addr),
    .rf_o_ce       (rf_o_ce)
  );

  // -------------------------------------------------------------------------
  // Scoreboard counters and checker
  // -------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [DWIDTH-1:0] obs,
                       input logic [DWIDTH-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  // Inputs are applied 1 ns after a rising edge and outputs are sampled at
  // the same point, well clear of the active edge.
  task automatic drive(input logic we, input logic [AWIDTH-1:0] rd,
                       input logic [DWIDTH-1:0] data,
                       input logic ce, input logic [AWIDTH-1:0] rs1,
                       input logic [AWIDTH-1:0] rs2,
                       input logic stall, input logic flush);
    rf_i_we       = we;
    rf_i_rd_addr  = rd;
    rf_i_rd_data  = data;
    rf_i_ce       = ce;
    rf_i_rs1_addr = rs1;
    rf_i_rs2_addr = rs2;
    rf_i_stall    = stall;
    rf_i_flush    = flush;
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Check the full output set in one call.
  task automatic check_out(input string tag,
                           input logic [DWIDTH-1:0] d1, input logic [DWIDTH-1:0] d2,
                           input logic [AWIDTH-1:0] a1, input logic [AWIDTH-1:0] a2,
                           input logic ce);
    check({tag, ".rs1_data"}, rf_o_rs1_data, d1);
    check({tag, ".rs2_data"}, rf_o_rs2_data, d2);
    check({tag, ".rs1_addr"}, DWIDTH'(rf_o_rs1_addr), DWIDTH'(a1));
    check({tag, ".rs2_addr"}, DWIDTH'(rf_o_rs2_addr), DWIDTH'(a2));
    check({tag, ".ce"}, DWIDTH'(rf_o_ce), DWIDTH'(ce));
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    idle();
    #12;
    check_out("reset", 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    wb_rst = 1'b1;
    #1;
    @(posedge wb_clk);
    #1;

    // Fresh read after reset: x5 is cleared, x0 is zero.
    drive(1'b0, '0, '0, 1'b1, 5'd5, 5'd0, 1'b0, 1'b0);
    step();
    check_out("rd_after_reset", 32'h0, 32'h0, 5'd5, 5'd0, 1'b1);

    // Write x5 with no read: valid drops, data/address hold.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    check_out("wr_x5_idle", 32'h0, 32'h0, 5'd5, 5'd0, 1'b0);
    idle();
    step();
    drive(1'b0, '0, '0, 1'b1, 5'd5, 5'd0, 1'b0, 1'b0);
    step();
    check_out("rd_x5", 32'hDEADBEEF, 32'h0, 5'd5, 5'd0, 1'b1);

    // Same-edge write of x7 bypassed to both ports.
    drive(1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 5'd7, 1'b0, 1'b0);
    step();
    check_out("bypass_both", 32'h12345678, 32'h12345678, 5'd7, 5'd7, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 5'd7, 5'd5, 1'b0, 1'b0);
    step();
    check_out("rd_x7_store", 32'h12345678, 32'hDEADBEEF, 5'd7, 5'd5, 1'b1);

    // x0: writes discarded, reads zero, no bypass to x0.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b1, 5'd0, 5'd7, 1'b0, 1'b0);
    step();
    check_out("rd_x0", 32'h0, 32'h12345678, 5'd0, 5'd7, 1'b1);
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    check_out("x0_no_bypass", 32'h0, 32'h0, 5'd0, 5'd0, 1'b1);

    // Stall refresh: capture x9=1, then stall while x9 becomes 2.
    drive(1'b1, 5'd9, 32'h1, 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b1, 5'd9, 5'd5, 1'b0, 1'b0);
    step();
    check_out("cap_x9", 32'h1, 32'hDEADBEEF, 5'd9, 5'd5, 1'b1);
    drive(1'b1, 5'd9, 32'h2, 1'b0, 5'd1, 5'd1, 1'b1, 1'b0);
    step();
    check_out("stall_refresh1", 32'h2, 32'hDEADBEEF, 5'd9, 5'd5, 1'b1);
    // Unrelated write during stall; new ce and addresses are ignored.
    drive(1'b1, 5'd10, 32'hAA, 1'b1, 5'd10, 5'd10, 1'b1, 1'b0);
    step();
    check_out("stall_other", 32'h2, 32'hDEADBEEF, 5'd9, 5'd5, 1'b1);
    // Port 2 refresh during stall.
    drive(1'b1, 5'd5, 32'h5555, 1'b0, '0, '0, 1'b1, 1'b0);
    step();
    check_out("stall_refresh2", 32'h2, 32'h5555, 5'd9, 5'd5, 1'b1);

    // Flush beats stall and ce; write still commits.
    drive(1'b1, 5'd3, 32'h55, 1'b1, 5'd3, 5'd3, 1'b1, 1'b1);
    step();
    check_out("flush_all", 32'h2, 32'h5555, 5'd9, 5'd5, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 5'd3, 5'd10, 1'b0, 1'b0);
    step();
    check_out("rd_x3_x10", 32'h55, 32'hAA, 5'd3, 5'd10, 1'b1);

    // Flush with ce only drops the read.
    drive(1'b0, '0, '0, 1'b1, 5'd7, 5'd9, 1'b0, 1'b1);
    step();
    check_out("flush_ce", 32'h55, 32'hAA, 5'd3, 5'd10, 1'b0);
    // Stall while valid is low keeps it low.
    drive(1'b0, '0, '0, 1'b1, 5'd7, 5'd9, 1'b1, 1'b0);
    step();
    check_out("stall_low", 32'h55, 32'hAA, 5'd3, 5'd10, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 5'd7, 5'd9, 1'b0, 1'b0);
    step();
    check_out("rd_x7_x9", 32'h12345678, 32'h2, 5'd7, 5'd9, 1'b1);

    // Asynchronous reset mid-cycle clears outputs and storage.
    drive(1'b1, 5'd12, 32'hC0FFEE, 1'b1, 5'd5, 5'd3, 1'b0, 1'b0);
    #2;
    wb_rst = 1'b0;
    #1;
    check_out("async_rst", 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    @(posedge wb_clk);
    #1;
    idle();
    wb_rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 5'd5, 5'd12, 1'b0, 1'b0);
    step();
    check_out("rd_after_rst2", 32'h0, 32'h0, 5'd5, 5'd12, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
